// File: rtl/apb_arbiter_2to1_pkg.sv
// Shared APB definitions for the 2:1 arbiter: FSM state encoding and the PPROT width.
package apb_pkg;

    localparam int APB_PROT_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_arbiter_2to1_rr_arb2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the requester not served last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt,
    output logic       valid
);

    always_comb begin
        valid = |req;
        gnt   = 1'b0;
        case (req)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = ~last;
            default: gnt = 1'b0;
        endcase
    end

endmodule

// File: rtl/apb_arbiter_2to1.sv
// Round-robin 2:1 APB arbiter that regenerates SETUP/ACCESS downstream and ends
// stuck transfers with PSLVERR through an ACCESS-cycle watchdog.
module apb_arbiter_2to1
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic [ADDR_W-1:0]     m0_paddr,
    input  logic                  m0_psel,
    input  logic                  m0_penable,
    input  logic [APB_PROT_W-1:0] m0_pprot,
    input  logic                  m0_pwrite,
    input  logic [DATA_W-1:0]     m0_pwdata,
    input  logic [DATA_W/8-1:0]   m0_pstrb,
    output logic                  m0_pready,
    output logic [DATA_W-1:0]     m0_prdata,
    output logic                  m0_pslverr,

    input  logic [ADDR_W-1:0]     m1_paddr,
    input  logic                  m1_psel,
    input  logic                  m1_penable,
    input  logic [APB_PROT_W-1:0] m1_pprot,
    input  logic                  m1_pwrite,
    input  logic [DATA_W-1:0]     m1_pwdata,
    input  logic [DATA_W/8-1:0]   m1_pstrb,
    output logic                  m1_pready,
    output logic [DATA_W-1:0]     m1_prdata,
    output logic                  m1_pslverr,

    output logic [ADDR_W-1:0]     out_paddr,
    output logic                  out_psel,
    output logic                  out_penable,
    output logic [APB_PROT_W-1:0] out_pprot,
    output logic                  out_pwrite,
    output logic [DATA_W-1:0]     out_pwdata,
    output logic [DATA_W/8-1:0]   out_pstrb,
    input  logic                  out_pready,
    input  logic [DATA_W-1:0]     out_prdata,
    input  logic                  out_pslverr
);

    localparam bit                WDOG_EN  = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    apb_state_e       state, state_next;
    logic             gnt, gnt_next;
    logic             last, last_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    logic             arb_gnt;
    logic             arb_valid;
    logic             drive_req;
    logic             rsp_pready;
    logic [DATA_W-1:0] rsp_prdata;
    logic             rsp_pslverr;
    logic             timeout_hit;

    // Requester penable carries no information here; the FSM owns the downstream phases.
    logic unused_penable;
    assign unused_penable = m0_penable ^ m1_penable;

    rr_arb2 u_rr_arb2 (
        .req   ({m1_psel, m0_psel}),
        .last  (last),
        .gnt   (arb_gnt),
        .valid (arb_valid)
    );

    assign timeout_hit = WDOG_EN && (cnt == CNT_LAST) && !out_pready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            gnt   <= 1'b0;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_next;
            gnt   <= gnt_next;
            last  <= last_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state;
        gnt_next    = gnt;
        last_next   = last;
        cnt_next    = cnt;
        out_psel    = 1'b0;
        out_penable = 1'b0;
        drive_req   = 1'b0;
        rsp_pready  = 1'b0;
        rsp_prdata  = '0;
        rsp_pslverr = 1'b0;

        case (state)
            IDLE: begin
                if (arb_valid) begin
                    gnt_next   = arb_gnt;
                    state_next = SETUP;
                end
            end

            SETUP: begin
                out_psel   = 1'b1;
                drive_req  = 1'b1;
                state_next = ACCESS;
            end

            ACCESS: begin
                out_psel    = 1'b1;
                out_penable = 1'b1;
                drive_req   = 1'b1;
                if (out_pready) begin
                    rsp_pready  = 1'b1;
                    rsp_prdata  = out_prdata;
                    rsp_pslverr = out_pslverr;
                    last_next   = gnt;
                    cnt_next    = '0;
                    state_next  = IDLE;
                end else if (timeout_hit) begin
                    // Abandon the downstream transfer in the same cycle the requester is released.
                    out_psel    = 1'b0;
                    out_penable = 1'b0;
                    rsp_pready  = 1'b1;
                    rsp_pslverr = 1'b1;
                    last_next   = gnt;
                    cnt_next    = '0;
                    state_next  = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        out_paddr  = '0;
        out_pprot  = '0;
        out_pwrite = 1'b0;
        out_pwdata = '0;
        out_pstrb  = '0;
        if (drive_req) begin
            if (gnt) begin
                out_paddr  = m1_paddr;
                out_pprot  = m1_pprot;
                out_pwrite = m1_pwrite;
                out_pwdata = m1_pwdata;
                out_pstrb  = m1_pstrb;
            end else begin
                out_paddr  = m0_paddr;
                out_pprot  = m0_pprot;
                out_pwrite = m0_pwrite;
                out_pwdata = m0_pwdata;
                out_pstrb  = m0_pstrb;
            end
        end
    end

    assign m0_pready  = rsp_pready  & ~gnt;
    assign m1_pready  = rsp_pready  &  gnt;
    assign m0_pslverr = rsp_pslverr & ~gnt;
    assign m1_pslverr = rsp_pslverr &  gnt;
    assign m0_prdata  = gnt ? '0 : rsp_prdata;
    assign m1_prdata  = gnt ? rsp_prdata : '0;

endmodule

// File: tb/tb_apb_arbiter_2to1.sv
// Directed bench for apb_arbiter_2to1: two instances (TIMEOUT 1024 and 8) share stimulus;
// a view mux selects which instance's outputs the checks look at.
module tb_apb_arbiter_2to1;

    logic        clock;
    logic        reset;

    logic [31:0] m0_paddr, m1_paddr;
    logic        m0_psel, m1_psel;
    logic        m0_penable, m1_penable;
    logic [2:0]  m0_pprot, m1_pprot;
    logic        m0_pwrite, m1_pwrite;
    logic [31:0] m0_pwdata, m1_pwdata;
    logic [3:0]  m0_pstrb, m1_pstrb;
    logic        out_pready;
    logic [31:0] out_prdata;
    logic        out_pslverr;

    logic        a_m0_pready, a_m0_pslverr, a_m1_pready, a_m1_pslverr;
    logic [31:0] a_m0_prdata, a_m1_prdata;
    logic [31:0] a_out_paddr, a_out_pwdata;
    logic        a_out_psel, a_out_penable, a_out_pwrite;
    logic [2:0]  a_out_pprot;
    logic [3:0]  a_out_pstrb;

    logic        b_m0_pready, b_m0_pslverr, b_m1_pready, b_m1_pslverr;
    logic [31:0] b_m0_prdata, b_m1_prdata;
    logic [31:0] b_out_paddr, b_out_pwdata;
    logic        b_out_psel, b_out_penable, b_out_pwrite;
    logic [2:0]  b_out_pprot;
    logic [3:0]  b_out_pstrb;

    logic        use_b;
    logic        v_m0_pready, v_m0_pslverr, v_m1_pready, v_m1_pslverr;
    logic [31:0] v_m0_prdata, v_m1_prdata;
    logic [31:0] v_out_paddr, v_out_pwdata;
    logic        v_out_psel, v_out_penable, v_out_pwrite;
    logic [2:0]  v_out_pprot;
    logic [3:0]  v_out_pstrb;

    int checks;
    int errors;

    apb_arbiter_2to1 #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(1024), .CNT_W(16)) dut_a (
        .clock(clock), .reset(reset),
        .m0_paddr(m0_paddr), .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pprot(m0_pprot),
        .m0_pwrite(m0_pwrite), .m0_pwdata(m0_pwdata), .m0_pstrb(m0_pstrb),
        .m0_pready(a_m0_pready), .m0_prdata(a_m0_prdata), .m0_pslverr(a_m0_pslverr),
        .m1_paddr(m1_paddr), .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pprot(m1_pprot),
        .m1_pwrite(m1_pwrite), .m1_pwdata(m1_pwdata), .m1_pstrb(m1_pstrb),
        .m1_pready(a_m1_pready), .m1_prdata(a_m1_prdata), .m1_pslverr(a_m1_pslverr),
        .out_paddr(a_out_paddr), .out_psel(a_out_psel), .out_penable(a_out_penable),
        .out_pprot(a_out_pprot), .out_pwrite(a_out_pwrite), .out_pwdata(a_out_pwdata),
        .out_pstrb(a_out_pstrb), .out_pready(out_pready), .out_prdata(out_prdata),
        .out_pslverr(out_pslverr)
    );

    apb_arbiter_2to1 #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8), .CNT_W(16)) dut_b (
        .clock(clock), .reset(reset),
        .m0_paddr(m0_paddr), .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pprot(m0_pprot),
        .m0_pwrite(m0_pwrite), .m0_pwdata(m0_pwdata), .m0_pstrb(m0_pstrb),
        .m0_pready(b_m0_pready), .m0_prdata(b_m0_prdata), .m0_pslverr(b_m0_pslverr),
        .m1_paddr(m1_paddr), .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pprot(m1_pprot),
        .m1_pwrite(m1_pwrite), .m1_pwdata(m1_pwdata), .m1_pstrb(m1_pstrb),
        .m1_pready(b_m1_pready), .m1_prdata(b_m1_prdata), .m1_pslverr(b_m1_pslverr),
        .out_paddr(b_out_paddr), .out_psel(b_out_psel), .out_penable(b_out_penable),
        .out_pprot(b_out_pprot), .out_pwrite(b_out_pwrite), .out_pwdata(b_out_pwdata),
        .out_pstrb(b_out_pstrb), .out_pready(out_pready), .out_prdata(out_prdata),
        .out_pslverr(out_pslverr)
    );

    assign v_m0_pready   = use_b ? b_m0_pready   : a_m0_pready;
    assign v_m0_pslverr  = use_b ? b_m0_pslverr  : a_m0_pslverr;
    assign v_m0_prdata   = use_b ? b_m0_prdata   : a_m0_prdata;
    assign v_m1_pready   = use_b ? b_m1_pready   : a_m1_pready;
    assign v_m1_pslverr  = use_b ? b_m1_pslverr  : a_m1_pslverr;
    assign v_m1_prdata   = use_b ? b_m1_prdata   : a_m1_prdata;
    assign v_out_paddr   = use_b ? b_out_paddr   : a_out_paddr;
    assign v_out_pwdata  = use_b ? b_out_pwdata  : a_out_pwdata;
    assign v_out_psel    = use_b ? b_out_psel    : a_out_psel;
    assign v_out_penable = use_b ? b_out_penable : a_out_penable;
    assign v_out_pwrite  = use_b ? b_out_pwrite  : a_out_pwrite;
    assign v_out_pprot   = use_b ? b_out_pprot   : a_out_pprot;
    assign v_out_pstrb   = use_b ? b_out_pstrb   : a_out_pstrb;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    // Entered at posedge+1 of an IDLE cycle with the request already presented;
    // returns at posedge+1 of the IDLE cycle that follows the completion.
    task automatic run_xfer(input string tag, input int who, input logic [31:0] addr,
                            input logic wr, input logic [31:0] wdata, input logic [31:0] rdata,
                            input logic err, input int waits);
        smp();
        check({tag, ".idle_psel"}, v_out_psel, 0);
        check({tag, ".idle_paddr"}, v_out_paddr, 0);
        check({tag, ".idle_pready"}, {v_m1_pready, v_m0_pready}, 0);
        tick();
        smp();
        check({tag, ".setup_psel"}, v_out_psel, 1);
        check({tag, ".setup_penable"}, v_out_penable, 0);
        check({tag, ".setup_paddr"}, v_out_paddr, addr);
        check({tag, ".setup_pwrite"}, v_out_pwrite, wr);
        if (wr) check({tag, ".setup_pwdata"}, v_out_pwdata, wdata);
        check({tag, ".setup_pprot"}, v_out_pprot, (who == 1) ? 3'd5 : 3'd2);
        check({tag, ".setup_pstrb"}, v_out_pstrb, (who == 1) ? 4'h3 : 4'hF);
        tick();
        if (who == 1) m1_penable = 1'b1; else m0_penable = 1'b1;
        for (int i = 0; i < waits; i++) begin
            out_pslverr = 1'b1;
            out_prdata  = 32'h0BAD_0BAD;
            smp();
            check({tag, ".wait_penable"}, v_out_penable, 1);
            check({tag, ".wait_pready"}, {v_m1_pready, v_m0_pready}, 0);
            check({tag, ".wait_pslverr"}, {v_m1_pslverr, v_m0_pslverr}, 0);
            tick();
        end
        out_pready  = 1'b1;
        out_prdata  = rdata;
        out_pslverr = err;
        smp();
        check({tag, ".acc_penable"}, v_out_penable, 1);
        if (who == 1) begin
            check({tag, ".m1_pready"}, v_m1_pready, 1);
            check({tag, ".m1_prdata"}, v_m1_prdata, rdata);
            check({tag, ".m1_pslverr"}, v_m1_pslverr, err);
            check({tag, ".m0_pready"}, v_m0_pready, 0);
            check({tag, ".m0_pslverr"}, v_m0_pslverr, 0);
            check({tag, ".m0_prdata"}, v_m0_prdata, 0);
        end else begin
            check({tag, ".m0_pready"}, v_m0_pready, 1);
            check({tag, ".m0_prdata"}, v_m0_prdata, rdata);
            check({tag, ".m0_pslverr"}, v_m0_pslverr, err);
            check({tag, ".m1_pready"}, v_m1_pready, 0);
            check({tag, ".m1_pslverr"}, v_m1_pslverr, 0);
            check({tag, ".m1_prdata"}, v_m1_prdata, 0);
        end
        tick();
        out_pready  = 1'b0;
        out_prdata  = '0;
        out_pslverr = 1'b0;
        m0_penable  = 1'b0;
        m1_penable  = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        use_b  = 1'b0;
        reset  = 1'b0;
        m0_paddr = '0; m0_psel = 0; m0_penable = 0; m0_pprot = 3'd2; m0_pwrite = 0; m0_pwdata = '0; m0_pstrb = 4'hF;
        m1_paddr = '0; m1_psel = 0; m1_penable = 0; m1_pprot = 3'd5; m1_pwrite = 0; m1_pwdata = '0; m1_pstrb = 4'h3;
        out_pready = 0; out_prdata = '0; out_pslverr = 0;

        // Reset state
        smp();
        smp();
        check("rst.out_psel", v_out_psel, 0);
        check("rst.out_penable", v_out_penable, 0);
        check("rst.out_paddr", v_out_paddr, 0);
        check("rst.pready", {v_m1_pready, v_m0_pready}, 0);
        check("rst.pslverr", {v_m1_pslverr, v_m0_pslverr}, 0);
        check("rst.cnt", dut_a.cnt, 0);
        tick();
        reset = 1'b1;

        // Contention: both request together and keep requesting; grants alternate m0, m1, m0, m1
        m0_psel = 1; m0_pwrite = 1; m0_paddr = 32'h0000_0100; m0_pwdata = 32'h1111_1111;
        m1_psel = 1; m1_pwrite = 1; m1_paddr = 32'h0000_0200; m1_pwdata = 32'h2222_2222;
        run_xfer("t2.p1_m0", 0, 32'h0000_0100, 1, 32'h1111_1111, 32'h0, 0, 0);
        m0_paddr = 32'h0000_0104; m0_pwdata = 32'h3333_3333;
        run_xfer("t2.p1_m1", 1, 32'h0000_0200, 1, 32'h2222_2222, 32'h0, 0, 0);
        m1_paddr = 32'h0000_0204; m1_pwdata = 32'h4444_4444;
        run_xfer("t2.p2_m0", 0, 32'h0000_0104, 1, 32'h3333_3333, 32'h0, 0, 0);
        m0_psel = 0;
        run_xfer("t2.p2_m1", 1, 32'h0000_0204, 1, 32'h4444_4444, 32'h0, 0, 0);
        m1_psel = 0; m0_pwrite = 0; m1_pwrite = 0;

        // Single m0 read
        m0_psel = 1; m0_paddr = 32'h1000_0000; m0_pwdata = '0;
        run_xfer("t1", 0, 32'h1000_0000, 0, 32'h0, 32'hDEAD_BEEF, 0, 0);
        m0_psel = 0;

        // m1 write with downstream error
        m1_psel = 1; m1_pwrite = 1; m1_paddr = 32'h2000_0040; m1_pwdata = 32'hCAFE_F00D;
        run_xfer("t6", 1, 32'h2000_0040, 1, 32'hCAFE_F00D, 32'h0, 1, 0);
        m1_psel = 0; m1_pwrite = 0;
        smp();
        check("t6.after_m1_pslverr", v_m1_pslverr, 0);
        check("t6.after_m1_pready", v_m1_pready, 0);
        tick();

        // Five wait states, well under the watchdog limit
        m0_psel = 1; m0_paddr = 32'h3000_0000;
        run_xfer("t3", 0, 32'h3000_0000, 0, 32'h0, 32'h1234_5678, 0, 5);
        m0_psel = 0;
        check("t3.cnt_a", dut_a.cnt, 0);
        check("t3.cnt_b", dut_b.cnt, 0);

        // Watchdog expiry on the TIMEOUT=8 instance
        use_b = 1'b1;
        m0_psel = 1; m0_paddr = 32'h4000_0000;
        smp();
        check("t4.idle_psel", v_out_psel, 0);
        tick();
        smp();
        check("t4.setup_psel", v_out_psel, 1);
        tick();
        out_prdata = 32'h5555_AAAA;
        for (int i = 0; i < 7; i++) begin
            smp();
            check("t4.wait_penable", v_out_penable, 1);
            check("t4.wait_pready", v_m0_pready, 0);
            tick();
        end
        smp();
        check("t4.to_pready", v_m0_pready, 1);
        check("t4.to_pslverr", v_m0_pslverr, 1);
        check("t4.to_prdata", v_m0_prdata, 0);
        check("t4.to_psel", v_out_psel, 0);
        check("t4.to_penable", v_out_penable, 0);
        check("t4.to_m1_pready", v_m1_pready, 0);
        tick();
        out_prdata = '0;
        m0_psel = 0;
        m1_psel = 1; m1_paddr = 32'h4000_0010;
        run_xfer("t4.next", 1, 32'h4000_0010, 0, 32'h0, 32'h0F0F_0F0F, 0, 0);
        m1_psel = 0;
        use_b = 1'b0;

        // Asynchronous reset in the middle of an m1 ACCESS
        m1_psel = 1; m1_pwrite = 1; m1_paddr = 32'h5000_0000; m1_pwdata = 32'h7777_7777;
        smp();
        tick();
        smp();
        check("t5.setup_paddr", v_out_paddr, 32'h5000_0000);
        tick();
        smp();
        check("t5.access_penable", v_out_penable, 1);
        #2;
        reset = 1'b0;
        #1;
        check("t5.rst_psel", v_out_psel, 0);
        check("t5.rst_penable", v_out_penable, 0);
        check("t5.rst_paddr", v_out_paddr, 0);
        check("t5.rst_pready", {v_m1_pready, v_m0_pready}, 0);
        tick();
        check("t5.rst_hold_psel", v_out_psel, 0);
        reset = 1'b1;
        m0_psel = 1; m0_pwrite = 0; m0_paddr = 32'h5100_0000;
        run_xfer("t5.tie_m0", 0, 32'h5100_0000, 0, 32'h0, 32'hA5A5_5A5A, 0, 0);
        m0_psel = 0;
        run_xfer("t5.then_m1", 1, 32'h5000_0000, 1, 32'h7777_7777, 32'h0, 0, 0);
        m1_psel = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
